pwm_multi_channel: RTL

//  Parametrised successor to the fixed 16-output PWM block. Drives NUM_CH outputs from one shared

---
 rtl/pwm_pkg.sv | 9 +
 rtl/pwm_timebase.sv | 42 ++++
 rtl/pwm_multi_channel.sv | 66 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: default build parameters and period helper shared by the PWM block
package pwm_pkg;
  localparam int NUM_CH_DEF  = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int PRESC_W_DEF = 8;
  function automatic int period_of(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared prescaler and period counter
//   clk_i, rst_ni   clock, synchronous active-low reset
//   prescale_i      prescaler terminal value (tick every prescale_i+1 clocks)
//   cnt_o           period counter, 0..PERIOD-1
//   wrap_o          combinational, high on the tick that wraps the counter
//   period_end_o    registered wrap, one-cycle pulse as the counter becomes 0
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               wrap_o,
  output logic               period_end_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(period_of(CNT_W) - 1);
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pe_q, tick;
  // >= rather than == so lowering prescale below the running count ticks at once
  assign tick    = presc_q >= prescale_i;
  assign wrap_o  = tick && cnt_q == LAST;
  assign presc_d = tick ? '0 : PRESC_W'(presc_q + 1'b1);
  assign cnt_d   = !tick ? cnt_q : wrap_o ? '0 : CNT_W'(cnt_q + 1'b1);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      presc_q <= '0;
      cnt_q   <= '0;
      pe_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pe_q    <= wrap_o;
    end
  end
  assign cnt_o        = cnt_q;
  assign period_end_o = pe_q;
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: NUM_CH PWM outputs on one shared timebase with period-aligned duty updates
//   clk_i, rst_ni   clock, synchronous active-low reset
//   en_out_i        per-channel output enable (0 forces output low)
//   en_pwm_i        per-channel PWM enable (0 gives static high when output enabled)
//   prescale_i      timebase prescaler terminal value
//   duty_wr_i       one-cycle duty write strobe for duty_ch_i / duty_val_i
//   period_end_o    one-cycle pulse on counter wrap
//   out_o           registered channel outputs
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter  int NUM_CH  = NUM_CH_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int PRESC_W = PRESC_W_DEF,
  localparam int CH_W    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_CH-1:0]  en_out_i,
  input  logic [NUM_CH-1:0]  en_pwm_i,
  input  logic [PRESC_W-1:0] prescale_i,
  input  logic               duty_wr_i,
  input  logic [CH_W-1:0]    duty_ch_i,
  input  logic [CNT_W-1:0]   duty_val_i,
  output logic               period_end_o,
  output logic [NUM_CH-1:0]  out_o
);
  localparam logic [CNT_W-1:0] PERIOD = CNT_W'(period_of(CNT_W));
  localparam logic [CH_W:0]    NCH    = (CH_W + 1)'(NUM_CH);
  logic [CNT_W-1:0]  cnt;
  logic              wrap, ch_ok;
  logic [NUM_CH-1:0] out_d, out_q;
  pwm_timebase #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_tb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .prescale_i  (prescale_i),
    .cnt_o       (cnt),
    .wrap_o      (wrap),
    .period_end_o(period_end_o)
  );
  assign ch_ok = {1'b0, duty_ch_i} < NCH;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] pend_q, pend_d, act_q, act_d;
    logic             hit, pwm;
    assign hit    = duty_wr_i && ch_ok && duty_ch_i == CH_W'(c);
    assign pend_d = hit ? duty_val_i : pend_q;
    // active loads the post-write pending value so a write on the wrap cycle is not delayed
    assign act_d  = wrap ? pend_d : act_q;
    assign pwm    = act_q == PERIOD ? 1'b1 : cnt < act_q;
    assign out_d[c] = en_out_i[c] & (~en_pwm_i[c] | pwm);
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        pend_q <= '0;
        act_q  <= '0;
      end else begin
        pend_q <= pend_d;
        act_q  <= act_d;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) out_q <= '0;
    else         out_q <= out_d;
  end
  assign out_o = out_q;
endmodule
